// File: rtl/mem_access_unit.sv
// Load/store front end for one port of the word-wide block RAM: byte/half/word access with lane steering.
// Optional: define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned and size-3 requests with resp_error.
module mem_access_unit #(
    parameter int ADDR_BITS = 7,
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [WORD_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_BITS-1:0] resp_rdata,
    output logic                 resp_error,
    output logic                 mem_reset,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_rd_en,
    output logic [3:0]           mem_wr_en,
    output logic [WORD_BITS-1:0] mem_wr_data,
    input  logic [WORD_BITS-1:0] mem_rd_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   r_write;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [WORD_BITS-1:0]   r_wdata;
    logic [WORD_BITS-1:0]   rdata_q;
    logic                   accept;
    logic                   req_bad;
    logic [1:0]             eff_size;
    logic [1:0]             lane;

    function automatic logic [3:0] wr_lanes(input logic [1:0] sz, input logic [1:0] ln);
        logic [3:0] en;
        case (sz)
            2'd0:    en = 4'b0001 << ln;
            2'd1:    en = ln[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    function automatic logic [WORD_BITS-1:0] wr_steer(input logic [1:0] sz, input logic [WORD_BITS-1:0] wd);
        logic [WORD_BITS-1:0] d;
        case (sz)
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [WORD_BITS-1:0] ld_format(input logic [WORD_BITS-1:0] rd,
                                                       input logic [1:0] sz,
                                                       input logic [1:0] ln,
                                                       input logic uns);
        logic [WORD_BITS-1:0] sh;
        logic [WORD_BITS-1:0] res;
        sh = rd >> {ln, 3'b000};
        case (sz)
            2'd0:    res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic resp_error_q;

    assign req_bad    = (req_size == 2'd3) ||
                        ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign resp_error = resp_error_q;
`else
    assign req_bad    = 1'b0;
    assign resp_error = 1'b0;
`endif

    assign accept = req_valid && req_ready;

    // Size 3 behaves as word and misaligned offsets are forced down; trapped requests never reach ISSUE.
    always_comb begin
        eff_size = (r_size == 2'd3) ? 2'd2 : r_size;
        case (eff_size)
            2'd0:    lane = r_addr[1:0];
            2'd1:    lane = {r_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = '0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                req_ready = reset_n;
                if (accept) begin
                    state_nxt = req_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (r_write) begin
                    mem_wr_en   = wr_lanes(eff_size, lane);
                    mem_wr_data = wr_steer(eff_size, r_wdata);
                    state_nxt   = RESP;
                end else begin
                    mem_rd_en   = 1'b1;
                    state_nxt   = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write    <= 1'b0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            rdata_q    <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            resp_error_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        rdata_q    <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        resp_error_q <= req_bad;
`endif
                    end
                end
                CAPTURE: begin
                    rdata_q <= ld_format(mem_rd_data, eff_size, lane, r_unsigned);
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata  = rdata_q;
    assign mem_reset   = 1'b0;
    assign mem_address = {r_addr[ADDR_BITS-1:2], 2'b00};

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference memory, registered-read RAM model, directed + random traffic.
module tb_mem_access_unit;

    localparam int AB = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = '0;
    logic          req_unsigned = 1'b0;
    logic [AB-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          mem_reset;
    logic [AB-1:0] mem_address;
    logic          mem_rd_en;
    logic [3:0]    mem_wr_en;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0]   ram [32];
    logic [7:0]    ref_mem [128];
    logic          do_init = 1'b0;
    int unsigned   rd_cnt = 0;
    int unsigned   wr_cnt = 0;
    logic [3:0]    last_wr_en = '0;
    logic [31:0]   last_wr_data = '0;
    logic [AB-1:0] last_addr = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_BITS(AB), .WORD_BITS(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_reset(mem_reset),
        .mem_address(mem_address), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    // Registered-read block RAM with byte write enables.
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 32; i++)
                ram[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        end else begin
            if (mem_rd_en) begin
                mem_rd_data <= ram[mem_address[AB-1:2]];
                rd_cnt      <= rd_cnt + 1;
                last_addr   <= mem_address;
            end
            if (mem_wr_en != 4'b0000) begin
                for (int l = 0; l < 4; l++)
                    if (mem_wr_en[l]) ram[mem_address[AB-1:2]][8*l +: 8] <= mem_wr_data[8*l +: 8];
                wr_cnt       <= wr_cnt + 1;
                last_wr_en   <= mem_wr_en;
                last_wr_data <= mem_wr_data;
                last_addr    <= mem_address;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [AB-1:0] a, input logic [31:0] wd, input int hold);
        int          n;
        int          base;
        int          lat;
        logic        bad;
        logic [31:0] exp_rd, exp_data, held;
        logic [3:0]  exp_en;
        int unsigned rd0, wr0;

        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        bad = (sz == 2'd3) || ((int'(a) % n) != 0);
`else
        bad = 1'b0;
`endif
        base     = int'(a) - (int'(a) % n);
        exp_rd   = '0;
        exp_en   = '0;
        exp_data = '0;
        for (int l = 0; l < 4; l++) exp_data[8*l +: 8] = wd[8*(l % n) +: 8];
        if (!bad && w) begin
            for (int k = 0; k < n; k++) begin
                ref_mem[base+k]       = wd[8*k +: 8];
                exp_en[(base+k) % 4]  = 1'b1;
            end
        end
        if (!bad && !w) begin
            for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = ref_mem[base+k];
            if (!u && n < 4 && exp_rd[8*n-1])
                for (int k = n; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
        end

        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, bad ? 1 : (w ? 2 : 3));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_error", {31'd0, resp_error}, {31'd0, bad});
        held = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, held);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
        chk("rd_pulses", rd_cnt - rd0, (!bad && !w) ? 32'd1 : 32'd0);
        chk("wr_pulses", wr_cnt - wr0, (!bad && w) ? 32'd1 : 32'd0);
        if (!bad) chk("mem_address", {25'd0, last_addr}, base & ~3);
        if (!bad && w) begin
            chk("wr_en", {28'd0, last_wr_en}, {28'd0, exp_en});
            chk("wr_data", last_wr_data, exp_data);
        end
    endtask

    initial begin
        int unsigned wr_before;

        for (int i = 0; i < 128; i++) ref_mem[i] = 8'($urandom);
        do_init = 1'b1;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_mem_wr_en", {28'd0, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", {25'd0, mem_address}, 32'd0);
        chk("rst_mem_wr_data", mem_wr_data, 32'd0);
        chk("mem_reset", {31'd0, mem_reset}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        do_init = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, 7'h10, 32'h11223344, 0);
        do_req(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b0, 7'h13, 32'h0, 0);
        do_req(1'b1, 2'd0, 1'b0, 7'h11, 32'h000000F0, 0);
        do_req(1'b0, 2'd0, 1'b0, 7'h11, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b1, 7'h11, 32'h0, 0);
        do_req(1'b1, 2'd1, 1'b0, 7'h12, 32'h0000BEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, 0);
        do_req(1'b0, 2'd1, 1'b0, 7'h12, 32'h0, 5);
        do_req(1'b0, 2'd1, 1'b0, 7'h13, 32'h0, 1);
        do_req(1'b0, 2'd3, 1'b1, 7'h11, 32'h0, 0);

        // Reset lands inside the store's ISSUE cycle, before the write edge.
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 7'h10;
        req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        wr_before = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("issue_wr_en", {28'd0, mem_wr_en}, 32'hF);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_wr_en_drop", {28'd0, mem_wr_en}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_no_write", wr_cnt - wr_before, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, 0);

        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   7'($urandom_range(0, 127)), $urandom, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store front end for one port of the dual-port word-wide block RAM.
- Takes byte/half/word load and store requests over a valid/ready handshake and generates word address, per-byte write enables and lane-replicated write data for the port.
- Captures the port's registered read data, then shifts and extends it into a right-aligned result.
- Sits between a core's memory stage (or the GPU command fetch) and port A or port B of the RAM.

Parameters:
- ADDR_BITS, 7, byte address width; matches the RAM's clog2(CAPACITY_BYTES).
- WORD_BITS, 32, data width; fixed at 32 (4 byte lanes); other values are unsupported.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_write  input  1  1=store, 0=load
- req_size  input  2  0=byte, 1=half, 2=word, 3=reserved
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  ADDR_BITS  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts the response
- resp_rdata  output  32  load result; 0 for stores
- resp_error  output  1  request was rejected (see Optional Feature)
- mem_reset  output  1  to the RAM port reset; constant 0
- mem_address  output  ADDR_BITS  byte address to the RAM port, low 2 bits = 0
- mem_rd_en  output  1  RAM port read enable
- mem_wr_en  output  4  RAM port byte write enables
- mem_wr_data  output  32  RAM port write data
- mem_rd_data  input  32  RAM port read data; valid 1 cycle after mem_rd_en

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- Reset (async, reset_n=0): state IDLE, all request registers 0, resp_valid=0, resp_rdata=0, resp_error=0, mem_rd_en=0, mem_wr_en=0, mem_address=0, mem_wr_data=0, req_ready=0 while reset_n is low.
- Reset mid-operation aborts the transaction; no pending write enable survives the reset.
- req_ready=1 only in IDLE.
- IDLE: on req_valid&&req_ready, register all req_* fields and go to ISSUE.
- ISSUE:
  - mem_address = {addr[ADDR_BITS-1:2], 2'b00}.
  - Loads: mem_rd_en=1, then go to CAPTURE.
  - Stores: mem_wr_en and mem_wr_data driven for exactly this one cycle, then go to RESP with resp_rdata=0.
- CAPTURE: format mem_rd_data and register it into resp_rdata, then go to RESP.
- mem_* outputs are decoded from state and registered request fields only; no combinational path from req_* to mem_*. Outside ISSUE, all enables are 0.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable until resp_ready.
  - On resp_ready, go to IDLE. A new request is accepted no earlier than the following cycle.
- Latency, counted from the accept edge:
  - Load: resp_valid rises 3 cycles later.
  - Store: resp_valid rises 2 cycles later.
  - Full throughput with resp_ready held high: load every 4 cycles, store every 3 cycles.
- Write lanes (a = addr[1:0]):
  - byte: wr_en = 4'b0001<<a, data = {4{wdata[7:0]}}
  - half: wr_en = 4'b0011<<{a[1],0}, data = {2{wdata[15:0]}}
  - word: wr_en = 4'hF, data = wdata
- Load format:
  - sh = rd_data >> (8*a).
  - byte result = ext(sh[7:0]); half result = ext(sh[15:0]); word result = rd_data.
  - ext is zero-extension when req_unsigned=1, sign-extension otherwise.
- Misaligned accesses: half with a[0]=1, or word with a!=0.
- Size 3: handling depends on the Optional Feature.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned or size-3 requests skip ISSUE/CAPTURE and go IDLE→RESP on the next edge.
  - They produce resp_error=1 and resp_rdata=0.
  - No mem_rd_en or mem_wr_en pulse is generated.
- Undefined:
  - resp_error is tied to 0.
  - Size 3 is treated as word.
  - Misaligned addresses are force-aligned (half clears a[0], word clears a[1:0]) and the access proceeds normally.

Test Plan:
- Store word 0x11223344 @0x10, then load word @0x10 → mem_wr_en=4'hF for one cycle; read resp_rdata=0x11223344, resp_valid 3 cycles after accept.
- Load byte @0x13 signed → 0x00000011; store byte 0xF0 @0x11, then load byte @0x11 signed → 0xFFFFFFF0, unsigned → 0x000000F0; store asserts mem_wr_en=4'b0010, mem_wr_data=0xF0F0F0F0.
- Store half 0xBEEF @0x12 → mem_wr_en=4'b1100, then load word @0x10 → 0xBEEFF044; load half @0x12 signed → 0xFFFFBEEF.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready=0, no further mem_rd_en pulses.
- Load half @0x13: with macro → resp_error=1, resp_rdata=0, no mem_rd_en; without macro → reads @0x12 and returns 0xFFFFBEEF.
- Assert reset_n=0 during ISSUE of a store → mem_wr_en drops to 0 immediately; after release the word @0x10 is unchanged if reset preceded the write edge, and req_ready=1.
